dmem_responder: RTL and testbench

Memory-side responder for the data-memory interface driven by the multicycle control unit and datapath. It accepts one load/store request at a time. It services the request against an internal word-addressed RAM after a fixed, configurable latency. It returns read data or a completion with a ready/valid handshake, so the control FSM can stall in its memory-access states instead of assuming single-cycle memory.

---
 rtl/mem_pkg.sv | 14 +
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory interface types: responder FSM states and the DMemOp
// encoding used by the control unit.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic DMEM_OP_LOAD  = 1'b0;
    localparam logic DMEM_OP_STORE = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables; read data is
// registered on the access edge and held until the next access.
module dmem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        index,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Byte-masked write or registered read; a write returns zero read data.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wstrb[b]) begin
                        mem_r[index][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
                rdata <= '0;
            end else begin
                rdata <= mem_r[index];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, services it against the
// internal RAM after LATENCY cycles and returns it with a ready/valid handshake.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic                    req_ready_r, req_ready_nxt_s;
    logic                    resp_valid_r, resp_valid_nxt_s;
    logic                    resp_err_r, resp_err_nxt_s;
    logic                    rd_gate_r, rd_gate_nxt_s;
    logic                    cap_en_s, access_s, ram_en_s;

    logic                    cap_op_r;
    logic [ADDR_WIDTH-1:0]   cap_addr_r;
    logic [DATA_WIDTH-1:0]   cap_wdata_r;
    logic [BYTES-1:0]        cap_wstrb_r;

    logic [ADDR_WIDTH-1:0]   word_idx_s;
    logic                    addr_err_s;
    logic [DATA_WIDTH-1:0]   ram_rdata_s;

    assign word_idx_s = cap_addr_r >> $clog2(BYTES);
    assign addr_err_s = ((cap_addr_r & ADDR_WIDTH'(BYTES - 1)) != '0) ||
                        (word_idx_s >= ADDR_WIDTH'(DEPTH));

    // Reset must win over a coincident access edge so no store commits.
    assign ram_en_s = access_s & ~addr_err_s & ~reset;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (cap_op_r == DMEM_OP_STORE),
        .wstrb (cap_wstrb_r),
        .index (word_idx_s[IDX_W-1:0]),
        .wdata (cap_wdata_r),
        .rdata (ram_rdata_s)
    );

    // FSM state, latency counter and registered handshake/response flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            rd_gate_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            rd_gate_r    <= rd_gate_nxt_s;
        end
    end

    // Request capture; fields are frozen from accept until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_op_r    <= DMEM_OP_LOAD;
            cap_addr_r  <= '0;
            cap_wdata_r <= '0;
            cap_wstrb_r <= '0;
        end else if (cap_en_s) begin
            cap_op_r    <= req_op;
            cap_addr_r  <= req_addr;
            cap_wdata_r <= req_wdata;
            cap_wstrb_r <= req_wstrb;
        end
    end

    // Next-state, counter and response-flag logic.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        req_ready_nxt_s  = req_ready_r;
        resp_valid_nxt_s = resp_valid_r;
        resp_err_nxt_s   = resp_err_r;
        rd_gate_nxt_s    = rd_gate_r;
        cap_en_s         = 1'b0;
        access_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    cap_en_s        = 1'b1;
                    cnt_nxt_s       = CNT_W'(LATENCY - 1);
                    req_ready_nxt_s = 1'b0;
                    state_nxt_s     = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == '0) begin
                    access_s         = 1'b1;
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = addr_err_s;
                    rd_gate_nxt_s    = ~addr_err_s & (cap_op_r == DMEM_OP_LOAD);
                    state_nxt_s      = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt_s = 1'b0;
                    resp_err_nxt_s   = 1'b0;
                    rd_gate_nxt_s    = 1'b0;
                    req_ready_nxt_s  = 1'b1;
                    state_nxt_s      = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                cnt_nxt_s        = '0;
                req_ready_nxt_s  = 1'b1;
                resp_valid_nxt_s = 1'b0;
                resp_err_nxt_s   = 1'b0;
                rd_gate_nxt_s    = 1'b0;
            end
        endcase
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = {DATA_WIDTH{rd_gate_r}} & ram_rdata_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: expected responses come from a
// byte-strobed reference memory and are queued at request time.
module tb_dmem_responder;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [int];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    dmem_responder #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (64),
        .DEPTH      (256),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: computes the expected response and applies stores.
    task automatic push_expect(input logic op, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wstrb);
        exp_t        e;
        logic [63:0] idx;
        logic [63:0] v;
        idx = addr >> 3;
        if (addr[2:0] != 3'd0 || idx >= 64'd256) begin
            e.err = 1'b1; e.rdata = 64'd0;
        end else if (op == 1'b0) begin
            e.err = 1'b0;
            e.rdata = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 64'd0;
        end else begin
            v = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 64'd0;
            for (int b = 0; b < 8; b++)
                if (wstrb[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
            model_mem[int'(idx)] = v;
            e.err = 1'b0; e.rdata = 64'd0;
        end
        exp_q.push_back(e);
    endtask

    // Present a request; returns #1 after the accepting edge with inputs scrambled.
    task automatic send_req(input logic op, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wstrb);
        chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
        push_expect(op, addr, wdata, wstrb);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = ~op; req_addr = 64'h13;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wstrb = 8'hFF;
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    // Wait for resp_valid, check latency and compare against the scoreboard head.
    task automatic get_resp(input string tag);
        int   k;
        exp_t e;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'(LATENCY));
        e = exp_q.pop_front();
        chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, e.err});
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
    endtask

    // Let the response handshake complete and confirm return to IDLE.
    task automatic finish_resp(input string tag);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] hold_rdata;
        logic        hold_err;

        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_wstrb = 8'd0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);

        send_req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        get_resp("store_full"); finish_resp("store_full");
        send_req(1'b0, 64'h10, 64'd0, 8'd0);
        get_resp("load_full"); finish_resp("load_full");

        send_req(1'b1, 64'h10, 64'h11223344_55667788, 8'h0F);
        get_resp("store_strb"); finish_resp("store_strb");
        send_req(1'b0, 64'h10, 64'd0, 8'd0);
        get_resp("load_strb"); finish_resp("load_strb");

        send_req(1'b1, 64'h18, 64'hFFFF_0000_FFFF_0000, 8'h00);
        get_resp("store_nostrb"); finish_resp("store_nostrb");

        send_req(1'b0, 64'h13, 64'd0, 8'd0);
        get_resp("load_misalign"); finish_resp("load_misalign");
        send_req(1'b1, 64'h800, 64'h0123_4567_89AB_CDEF, 8'hFF);
        get_resp("store_range"); finish_resp("store_range");
        send_req(1'b0, 64'h10, 64'd0, 8'd0);
        get_resp("reload_after_err"); finish_resp("reload_after_err");

        resp_ready = 1'b0;
        send_req(1'b0, 64'h10, 64'd0, 8'd0);
        get_resp("bp_load");
        hold_rdata = resp_rdata; hold_err = resp_err;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", {63'd0, resp_valid}, 64'd1);
            chk("bp_rdata_held", resp_rdata, hold_rdata);
            chk("bp_err_held", {63'd0, resp_err}, {63'd0, hold_err});
            chk("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        finish_resp("bp_release");

        send_req(1'b1, 64'h18, 64'h5555, 8'hFF);
        get_resp("store_prior"); finish_resp("store_prior");

        // Abandoned store: driven by hand so the model never sees it.
        req_valid = 1'b1; req_op = 1'b1; req_addr = 64'h18;
        req_wdata = 64'hAAAA; req_wstrb = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        send_req(1'b0, 64'h18, 64'd0, 8'd0);
        get_resp("load_after_midrst"); finish_resp("load_after_midrst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
